// File: rtl/fios_pe_row_seq.sv
`timescale 1ns/1ps
// One FIOS outer-loop row: T' = (T + a*B + m*P) / 2^W over an S+1 beat operand stream.
// m is derived from beat 0, then each further beat yields one result word; the top word follows.
module fios_pe_row_seq #(
  parameter int unsigned W = 17,
  parameter int unsigned S = 16,
  localparam int unsigned CNT_W = $clog2(S + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     p_prime_0_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     p_i,
  input  logic [W-1:0]     t_i,
  output logic             res_valid_o,
  output logic [W-1:0]     res_o,
  output logic [CNT_W-1:0] res_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned UW = 2 * W + 1;
  localparam int unsigned VW = 2 * W + 2;

  typedef enum logic [2:0] {IDLE, ROW0, MCALC1, MCALC2, ROW, FLUSH} state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     pp_q;
  logic [W-1:0]     p0_q;
  logic [W-1:0]     m_q;
  logic [UW-1:0]    u_q;
  logic [W+1:0]     carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             last_beat;
  logic [W-1:0]     b_eff;
  logic [W-1:0]     p_eff;
  logic [W-1:0]     p_sel;
  logic [2*W-1:0]   prod_ab;
  logic [2*W-1:0]   prod_mp;
  logic [UW-1:0]    u_next;
  logic [VW-1:0]    acc_in;
  logic [VW-1:0]    v;
  logic [W-1:0]     m_next;

  // MCALC2 reuses the row adder and m*p multiplier, so the initial carry
  // and the per-beat carry both come out of v[VW-1:W].
  always_comb begin
    last_beat = (state == ROW) && (cnt_q == CNT_W'(S));
    b_eff     = last_beat ? '0 : b_i;
    p_eff     = last_beat ? '0 : p_i;
    p_sel     = (state == MCALC2) ? p0_q : p_eff;
    prod_ab   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_eff};
    prod_mp   = {{W{1'b0}}, m_q} * {{W{1'b0}}, p_sel};
    u_next    = UW'(t_i) + UW'(prod_ab);
    acc_in    = (state == MCALC2) ? VW'(u_q)
                                  : VW'(t_i) + VW'(prod_ab) + VW'(carry_q);
    v         = acc_in + VW'(prod_mp);
    m_next    = W'(u_q[W-1:0] * pp_q);
  end

  assign in_ready_o = (state == ROW0) || (state == ROW);
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      a_q         <= '0;
      pp_q        <= '0;
      p0_q        <= '0;
      m_q         <= '0;
      u_q         <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
      res_idx_o   <= '0;
      done_o      <= 1'b0;
    end else begin
      res_valid_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_q   <= a_i;
            pp_q  <= p_prime_0_i;
            cnt_q <= '0;
            state <= ROW0;
          end
        end
        ROW0: begin
          if (in_valid_i) begin
            u_q   <= u_next;
            p0_q  <= p_i;
            cnt_q <= CNT_W'(1);
            state <= MCALC1;
          end
        end
        MCALC1: begin
          m_q   <= m_next;
          state <= MCALC2;
        end
        MCALC2: begin
          carry_q <= v[VW-1:W];
          state   <= ROW;
        end
        ROW: begin
          if (in_valid_i) begin
            res_valid_o <= 1'b1;
            res_o       <= v[W-1:0];
            res_idx_o   <= cnt_q - CNT_W'(1);
            carry_q     <= v[VW-1:W];
            if (last_beat) begin
              state <= FLUSH;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          res_valid_o <= 1'b1;
          res_o       <= carry_q[W-1:0];
          res_idx_o   <= CNT_W'(S);
          done_o      <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_pe_row_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for fios_pe_row_seq: four instances at different W/S share the operand buses.
module tb_fios_pe_row_seq;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        in_valid;
  logic [16:0] a_d, pp_d, b_d, p_d, t_d;
  logic [3:0]  rdy_v, rv, busy_v, done_v;
  logic [7:0]  ro0, ro1;
  logic [16:0] ro2, ro3;
  logic [1:0]  ri0;
  logic [0:0]  ri1;
  logic [4:0]  ri2;
  logic [3:0]  ri3;

  typedef struct {int inst; int idx; longint data; bit done;} exp_t;
  exp_t q[$];

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint start_cyc = 0;
  longint exp_lat = -1;
  logic [16:0] bb[17], pb[17], tv[17], mres[17];
  int     stb[17];
  longint cap[17];

  fios_pe_row_seq #(.W(8), .S(2)) u_d0 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start_v[0]), .a_i(a_d[7:0]), .p_prime_0_i(pp_d[7:0]),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[0]), .b_i(b_d[7:0]), .p_i(p_d[7:0]), .t_i(t_d[7:0]),
    .res_valid_o(rv[0]), .res_o(ro0), .res_idx_o(ri0), .busy_o(busy_v[0]), .done_o(done_v[0]));
  fios_pe_row_seq #(.W(8), .S(1)) u_d1 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start_v[1]), .a_i(a_d[7:0]), .p_prime_0_i(pp_d[7:0]),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[1]), .b_i(b_d[7:0]), .p_i(p_d[7:0]), .t_i(t_d[7:0]),
    .res_valid_o(rv[1]), .res_o(ro1), .res_idx_o(ri1), .busy_o(busy_v[1]), .done_o(done_v[1]));
  fios_pe_row_seq #(.W(17), .S(16)) u_d2 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start_v[2]), .a_i(a_d), .p_prime_0_i(pp_d),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[2]), .b_i(b_d), .p_i(p_d), .t_i(t_d),
    .res_valid_o(rv[2]), .res_o(ro2), .res_idx_o(ri2), .busy_o(busy_v[2]), .done_o(done_v[2]));
  fios_pe_row_seq #(.W(17), .S(8)) u_d3 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start_v[3]), .a_i(a_d), .p_prime_0_i(pp_d),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[3]), .b_i(b_d), .p_i(p_d), .t_i(t_d),
    .res_valid_o(rv[3]), .res_o(ro3), .res_idx_o(ri3), .busy_o(busy_v[3]), .done_o(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_one(input int inst, input int idx, input longint data, input bit done);
    exp_t e;
    e.inst = inst; e.idx = idx; e.data = data; e.done = done;
    q.push_back(e);
  endtask

  // Full-precision reference: result = (T + a*B + m*P) >> w, split into words.
  task automatic model_push(input int sel, input int w, input int s, input logic [16:0] a,
                            input logic [16:0] pp, input int nlim);
    logic [511:0] tt, bw, pw, x, r;
    logic [63:0]  mask, u, m;
    mask = (64'd1 << w) - 64'd1;
    u = 64'(tv[0]) + 64'(a) * 64'(bb[0]);
    m = ((u & mask) * 64'(pp)) & mask;
    tt = '0; bw = '0; pw = '0;
    for (int k = 0; k <= s; k++) begin
      tt = tt | (512'(tv[k]) << (k * w));
      if (k < s) begin
        bw = bw | (512'(bb[k]) << (k * w));
        pw = pw | (512'(pb[k]) << (k * w));
      end
    end
    x = tt + 512'(a) * bw + 512'(m) * pw;
    r = x >> w;
    for (int k = 0; k <= s; k++) begin
      mres[k] = 17'((r >> (k * w)) & 512'(mask));
      if (k < nlim) push_one(sel, k, longint'(mres[k]), k == s);
    end
  endtask

  function automatic logic [16:0] neg_inv(input logic [16:0] p0);
    logic [31:0] x;
    x = 32'(p0);
    for (int i = 0; i < 5; i++) x = x * (32'd2 - 32'(p0) * x);
    return 17'(~x + 32'd1);
  endfunction

  task automatic run_row(input int sel, input int s, input logic [16:0] a, input logic [16:0] pp,
                         input int rst_beat, input bit repulse, input longint lat);
    int guard;
    a_d = a; pp_d = pp; start_v[sel] = 1'b1;
    start_cyc = cyc; exp_lat = lat;
    @(posedge clk); #1;
    start_v = '0;
    for (int i = 0; i <= s; i++) begin
      if (stb[i] > 0) begin
        in_valid = 1'b0;
        repeat (stb[i]) begin @(posedge clk); #1; end
      end
      b_d = bb[i]; p_d = pb[i]; t_d = tv[i]; in_valid = 1'b1;
      if (repulse && i >= 1) begin start_v[sel] = 1'b1; a_d = ~a; pp_d = ~pp; end
      if (i == rst_beat) rst_n = 1'b0;
      guard = 0;
      while (!rdy_v[sel] && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) begin
        failures++; checks++;
        $display("FAIL in_ready_timeout inst=%0d beat=%0d actual=0 expected=1", sel, i);
        in_valid = 1'b0; start_v = '0; rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      start_v = '0; a_d = a; pp_d = pp;
      if (i == rst_beat) begin
        chk("reset_outputs", longint'({rdy_v[sel], rv[sel], busy_v[sel], done_v[sel], ro2, ri2}), 0);
        rst_n = 1'b1; in_valid = 1'b0;
        return;
      end
      if (i == 0) begin
        chk("ready_mcalc1", rdy_v[sel], 0);
        @(posedge clk); #1;
        chk("ready_mcalc2", rdy_v[sel], 0);
      end
    end
    in_valid = 1'b0;
    if (repulse) begin start_v[sel] = 1'b1; a_d = ~a; pp_d = ~pp; end
    @(posedge clk); #1;
    start_v = '0; a_d = a; pp_d = pp;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin @(posedge clk); g++; end
    #1;
    chk("scoreboard_empty", q.size(), 0);
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < 17; k++) stb[k] = 0;
  endtask

  task automatic rand_ops(input int s, output logic [16:0] a, output logic [16:0] pp);
    for (int k = 0; k <= s; k++) begin
      bb[k] = 17'($urandom); pb[k] = 17'($urandom); tv[k] = 17'($urandom);
    end
    pb[0] = pb[0] | 17'd1;
    a = 17'($urandom);
    pp = neg_inv(pb[0]);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      longint ad, ai;
      exp_t e;
      case (g)
        0: begin ad = longint'(ro0); ai = longint'(ri0); end
        1: begin ad = longint'(ro1); ai = longint'(ri1); end
        2: begin ad = longint'(ro2); ai = longint'(ri2); end
        default: begin ad = longint'(ro3); ai = longint'(ri3); end
      endcase
      if (rv[g]) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL res_unexpected inst=%0d idx=%0d actual=%0h expected=none", g, ai, ad);
        end else begin
          e = q.pop_front();
          chk("res_inst", g, e.inst);
          chk("res_idx", ai, e.idx);
          chk("res_data", ad, e.data);
          chk("res_done", done_v[g], e.done);
          if (g == 3 && ai < 17) cap[ai] = ad;
          if (done_v[g] && exp_lat > 0) chk("done_latency", cyc - start_cyc, exp_lat);
        end
      end else if (done_v[g]) begin
        chk("done_without_valid", done_v[g], 0);
      end
    end
  end

  initial begin
    logic [16:0] a, pp;
    logic [16:0] aw[4], bcw[8], pcw[8];
    logic [511:0] rv_w, av, bv, pv;

    rst_n = 1'b0; start_v = '0; in_valid = 1'b0;
    a_d = '0; pp_d = '0; b_d = '0; p_d = '0; t_d = '0;
    clear_stalls();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst0", longint'({rdy_v[0], rv[0], busy_v[0], done_v[0], ro0, ri0}), 0);
    chk("reset_inst1", longint'({rdy_v[1], rv[1], busy_v[1], done_v[1], ro1, ri1}), 0);
    chk("reset_inst2", longint'({rdy_v[2], rv[2], busy_v[2], done_v[2], ro2, ri2}), 0);
    chk("reset_inst3", longint'({rdy_v[3], rv[3], busy_v[3], done_v[3], ro3, ri3}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic row W=8 S=2; beat-2 b/p carry junk that must be ignored
    bb[0] = 17'h02; pb[0] = 17'h01; tv[0] = 17'h00;
    bb[1] = 17'h00; pb[1] = 17'h00; tv[1] = 17'h00;
    bb[2] = 17'hA5; pb[2] = 17'h5A; tv[2] = 17'h00;
    push_one(0, 0, 'h01, 0); push_one(0, 1, 'h00, 0); push_one(0, 2, 'h00, 1);
    run_row(0, 2, 17'h01, 17'hFF, -1, 0, 7);
    chk("basic_m", longint'(u_d0.m_q), 'hFE);
    drain();

    // Max operands W=8 S=1
    bb[0] = 17'hFF; pb[0] = 17'hFF; tv[0] = 17'hFF;
    bb[1] = 17'h5A; pb[1] = 17'h3C; tv[1] = 17'hFF;
    push_one(1, 0, 'hFE, 0); push_one(1, 1, 'h01, 1);
    run_row(1, 1, 17'hFF, 17'h01, -1, 0, 6);
    chk("max_m", longint'(u_d1.m_q), 'h00);
    chk("max_carry", longint'(u_d1.carry_q), 'h001);
    drain();

    // start re-pulsed in ROW and FLUSH with corrupted a/p'0 must be ignored
    bb[0] = 17'h05; pb[0] = 17'h01; tv[0] = 17'h07;
    bb[1] = 17'h02; pb[1] = 17'h03; tv[1] = 17'h04;
    bb[2] = 17'h33; pb[2] = 17'h44; tv[2] = 17'h09;
    push_one(0, 0, 'hC9, 0); push_one(0, 1, 'h0B, 0); push_one(0, 2, 'h00, 1);
    run_row(0, 2, 17'h03, 17'hFF, -1, 1, -1);
    drain();
    // new row started the cycle after done
    bb[0] = 17'h02; pb[0] = 17'h01; tv[0] = 17'h00;
    bb[1] = 17'h00; pb[1] = 17'h00; tv[1] = 17'h00;
    bb[2] = 17'h00; pb[2] = 17'h00; tv[2] = 17'h00;
    push_one(0, 0, 'h01, 0); push_one(0, 1, 'h00, 0); push_one(0, 2, 'h00, 1);
    run_row(0, 2, 17'h01, 17'hFF, -1, 0, 7);
    drain();

    // W=17 S=16 with stalls after beats 0 and 5, then gap-free
    rand_ops(16, a, pp);
    clear_stalls(); stb[1] = 3; stb[6] = 3;
    model_push(2, 17, 16, a, pp, 17);
    run_row(2, 16, a, pp, -1, 0, -1);
    drain();
    clear_stalls();
    rand_ops(16, a, pp);
    model_push(2, 17, 16, a, pp, 17);
    run_row(2, 16, a, pp, -1, 0, 21);
    drain();

    // Reset during beat 7; only words 0..5 may appear
    rand_ops(16, a, pp);
    model_push(2, 17, 16, a, pp, 6);
    run_row(2, 16, a, pp, 7, 0, -1);
    repeat (4) @(posedge clk);
    drain();
    rand_ops(16, a, pp);
    model_push(2, 17, 16, a, pp, 17);
    run_row(2, 16, a, pp, -1, 0, 21);
    drain();

    // Four chained rows W=17 S=8, results fed back as t
    for (int k = 0; k < 8; k++) begin pcw[k] = 17'($urandom); bcw[k] = 17'($urandom); end
    pcw[0] = pcw[0] | 17'd1;
    pcw[7] = pcw[7] | 17'h10000;
    bcw[7] = 17'($urandom_range(0, int'(pcw[7]) - 1));
    for (int j = 0; j < 4; j++) aw[j] = 17'($urandom);
    for (int k = 0; k < 17; k++) mres[k] = '0;
    pp = neg_inv(pcw[0]);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k <= 8; k++) begin
        tv[k] = mres[k];
        bb[k] = (k < 8) ? bcw[k] : 17'($urandom);
        pb[k] = (k < 8) ? pcw[k] : 17'($urandom);
      end
      model_push(3, 17, 8, aw[j], pp, 9);
      run_row(3, 8, aw[j], pp, -1, 0, 13);
    end
    drain();
    rv_w = '0; av = '0; bv = '0; pv = '0;
    for (int k = 0; k <= 8; k++) rv_w = rv_w | (512'(cap[k]) << (17 * k));
    for (int k = 0; k < 8; k++) begin
      bv = bv | (512'(bcw[k]) << (17 * k));
      pv = pv | (512'(pcw[k]) << (17 * k));
    end
    for (int j = 0; j < 4; j++) av = av | (512'(aw[j]) << (17 * j));
    chk_wide("chain_congruence", (rv_w << 68) % pv, (av * bv) % pv);
    chk("chain_below_2p", longint'(rv_w < (pv << 1)), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
